// File: rtl/z16_pkg.sv
// rtl/z16_pkg.sv - shared Z16 widths and fetch FSM state encoding
package z16_pkg;
  localparam int Z16_XLEN        = 16;
  localparam int Z16_INSTR_BYTES = 2;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/z16_fetch_fifo.sv
// rtl/z16_fetch_fifo.sv - prefetch FIFO holding {pc,instr} pairs with flush
module z16_fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  assign do_pop  = i_pop & ~o_empty & ~i_flush;
  assign do_push = i_push & (~o_full | do_pop) & ~i_flush;

  // Flush rewinds the write pointer rather than the read pointer so the head stays stable.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= rd_ptr_q;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= i_wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/z16_fetch_unit.sv
// rtl/z16_fetch_unit.sv - Z16 fetch stage: PC walk, req/ack memory port, prefetch buffer, redirect
module z16_fetch_unit
  import z16_pkg::*;
#(
  parameter int                    DEPTH    = 4,
  parameter logic [Z16_XLEN-1:0]   RESET_PC = 16'h0000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic                o_mem_req,
  output logic [Z16_XLEN-1:0] o_mem_addr,
  input  logic                i_mem_ack,
  input  logic [Z16_XLEN-1:0] i_mem_rdata,
  output logic                o_instr_valid,
  output logic [Z16_XLEN-1:0] o_instr,
  output logic [Z16_XLEN-1:0] o_instr_pc,
  input  logic                i_instr_ready,
  input  logic                i_redirect,
  input  logic [Z16_XLEN-1:0] i_redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e          state_q, state_d;
  logic [Z16_XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [Z16_XLEN-1:0]   target_q, target_d;
  logic [Z16_XLEN-1:0]   redirect_target;
  logic                  push, pop, flush;
  logic [CW-1:0]         count;
  logic                  full, empty;
  logic [2*Z16_XLEN-1:0] head;
  logic [CW:0]           count_after;
  logic                  slot_after;

  assign redirect_target = {i_redirect_pc[Z16_XLEN-1:1], 1'b0};
  assign pop             = ~empty & i_instr_ready & ~i_redirect;
  // Occupancy after this cycle's push; decides whether another request is safe.
  assign count_after     = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  assign slot_after      = (count_after < (CW+1)'(DEPTH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    push       = 1'b0;
    flush      = i_redirect;
    unique case (state_q)
      FETCH_IDLE: begin
        if (i_redirect)  fetch_pc_d = redirect_target;
        else if (!full)  state_d    = FETCH_REQ;
      end
      FETCH_REQ: begin
        if (i_redirect) begin
          if (i_mem_ack) begin
            fetch_pc_d = redirect_target;
            state_d    = FETCH_IDLE;
          end else begin
            target_d   = redirect_target;
            state_d    = FETCH_DISCARD;
          end
        end else if (i_mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + Z16_XLEN'(Z16_INSTR_BYTES);
          state_d    = slot_after ? FETCH_REQ : FETCH_IDLE;
        end
      end
      FETCH_DISCARD: begin
        if (i_redirect) target_d = redirect_target;
        if (i_mem_ack) begin
          fetch_pc_d = i_redirect ? redirect_target : target_q;
          state_d    = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  z16_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*Z16_XLEN)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_pop   (pop),
    .i_flush (flush),
    .i_wdata ({fetch_pc_q, i_mem_rdata}),
    .o_rdata (head),
    .o_count (count),
    .o_full  (full),
    .o_empty (empty)
  );

  assign o_mem_req     = (state_q != FETCH_IDLE);
  assign o_mem_addr    = fetch_pc_q;
  assign o_instr_valid = ~empty;
  assign o_instr       = head[Z16_XLEN-1:0];
  assign o_instr_pc    = head[2*Z16_XLEN-1:Z16_XLEN];
endmodule

// File: tb/tb_z16_fetch_unit.sv
// tb/tb_z16_fetch_unit.sv - scoreboard bench for z16_fetch_unit
module tb_z16_fetch_unit;
  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  int          checks = 0;
  int          errors = 0;
  int          hs     = 0;
  int          cons   = 0;
  int          lat    = 0;
  logic        hold   = 1'b0;
  int          wait_cnt = 0;
  logic [15:0] exp_q[$];

  z16_fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_mem_req     (mem_req),
    .o_mem_addr    (mem_addr),
    .i_mem_ack     (mem_ack),
    .i_mem_rdata   (mem_rdata),
    .o_instr_valid (instr_valid),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .i_instr_ready (ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = mem_req && !hold && (wait_cnt >= lat);
  assign mem_rdata = mem_addr ^ 16'hA5A5;

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
    if (rst_n && mem_req && mem_ack) hs = hs + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid && ready && !redirect) begin
      cons++;
      if (exp_q.size() == 0) begin
        chk("unexpected_instr_pc", {16'h0, instr_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", {16'h0, instr_pc}, {16'h0, e});
        chk("sb_instr", {16'h0, instr}, {16'h0, e ^ 16'hA5A5});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    hold = 1'b0; lat = 0;
    exp_q.delete();
    step(); step();
    hs = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    #3;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);

    // 1: zero-wait streaming
    apply_reset();
    for (int i = 0; i < 16; i++) exp_q.push_back(16'(2*i));
    ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk("t1_req_c1", mem_req, 1);
    chk("t1_addr_c1", mem_addr, 16'h0000);
    chk("t1_valid_c1", instr_valid, 0);
    step();
    chk("t1_valid_c2", instr_valid, 1);
    chk("t1_pc_c2", instr_pc, 16'h0000);
    c0 = cons;
    repeat (8) step();
    chk("t1_rate", cons - c0, 8);
    drain(50);

    // 2: back-pressure fills exactly DEPTH
    apply_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(2*i));
    rst_n = 1'b1;
    repeat (10) step();
    chk("t2_reqs", hs, 4);
    chk("t2_req_low", mem_req, 0);
    chk("t2_valid", instr_valid, 1);
    chk("t2_head", instr_pc, 16'h0000);
    ready = 1'b1;
    step(); step();
    chk("t2_resume_req", mem_req, 1);
    chk("t2_resume_addr", mem_addr, 16'h0008);
    drain(50);

    // 3: ack delayed 3 cycles
    apply_reset();
    lat = 3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_req_hold", mem_req, 1);
      chk("t3_addr_hold", mem_addr, 16'h0000);
      chk("t3_no_push", hs, 0);
    end
    step();
    chk("t3_one_push", hs, 1);
    chk("t3_valid", instr_valid, 1);
    exp_q.push_back(16'h0000);
    drain(20);

    // 4: redirect while request pending -> DISCARD
    apply_reset();
    ready = 1'b1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0002); exp_q.push_back(16'h0004);
    rst_n = 1'b1;
    n = 0;
    while (!(mem_req && mem_addr == 16'h0006) && n < 20) begin
      step();
      n++;
    end
    chk("t4_reach6", mem_addr, 16'h0006);
    hold = 1'b1;
    step(); step();
    redirect = 1'b1; redirect_pc = 16'h0041;
    step();
    redirect = 1'b0;
    chk("t4_disc_req", mem_req, 1);
    chk("t4_disc_addr", mem_addr, 16'h0006);
    step();
    chk("t4_disc_addr2", mem_addr, 16'h0006);
    exp_q.push_back(16'h0040); exp_q.push_back(16'h0042);
    hold = 1'b0;
    step();
    chk("t4_idle_req", mem_req, 0);
    chk("t4_new_addr", mem_addr, 16'h0040);
    drain(30);

    // 5: redirect coinciding with ack and pop, FIFO holding 3
    apply_reset();
    rst_n = 1'b1;
    repeat (4) step();
    chk("t5_valid_pre", instr_valid, 1);
    chk("t5_head_pre", instr_pc, 16'h0000);
    chk("t5_addr_pre", mem_addr, 16'h0006);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0; ready = 1'b0;
    chk("t5_flush_valid", instr_valid, 0);
    chk("t5_flush_req", mem_req, 0);
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0102);
    step();
    chk("t5_restart_req", mem_req, 1);
    chk("t5_restart_addr", mem_addr, 16'h0100);
    drain(30);

    // 6: PC wrap and async reset mid-request
    apply_reset();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    rst_n = 1'b1;
    step();
    chk("t6_idle_req", mem_req, 0);
    chk("t6_addr_fffe", mem_addr, 16'hFFFE);
    redirect = 1'b0;
    step();
    chk("t6_req_fffe", mem_req, 1);
    step();
    chk("t6_addr_wrap", mem_addr, 16'h0000);
    exp_q.push_back(16'hFFFE); exp_q.push_back(16'h0000);
    drain(30);
    hold = 1'b1;
    step();
    chk("t6_mid_req", mem_req, 1);
    chk("t6_mid_valid", instr_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_req", mem_req, 0);
    chk("t6_async_valid", instr_valid, 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
